lsu_store_queue: RTL

Parametrised in-order store queue for the LSU, replacing the fixed single-port SQ embedded in the load/store unit. It accepts address-resolved stores from the LSU, marks them committed in program order at retire, and drains committed stores to the dcache write port. It also provides flush of speculative entries and same-cycle store-to-load forwarding (STLF) for the load path. Data alignment and byte-mask generation happen at insertion, not at drain.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_sq_fwd_match.sv | 30 +++
 rtl/lsu_store_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: access sizes, store-queue entry layout and size/mask helpers.
// Entry field widths are fixed here, so instantiating modules must keep XLEN/ID_W at these values.
package lsu_pkg;

    localparam int SQ_XLEN   = 64;
    localparam int SQ_ID_W   = 6;
    localparam int SQ_MASK_W = SQ_XLEN / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } inst_size_t;

    typedef struct packed {
        logic [SQ_ID_W-1:0]   id;
        logic [SQ_XLEN-1:0]   addr;
        logic [SQ_XLEN-1:0]   wdata;
        logic [SQ_MASK_W-1:0] mask;
    } sq_entry_t;

    function automatic logic [7:0] size_to_mask(input inst_size_t size);
        logic [7:0] m;
        case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic size_aligned(input inst_size_t size, input logic [2:0] off);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (off[0] == 1'b0);
            SIZE_W:  ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_sq_fwd_match.sv
// Youngest-match picker for store-to-load forwarding: age is the distance from head.
// Purely combinational; returns a one-hot entry select (all zero when nothing matches).
module lsu_sq_fwd_match #(
    parameter int NR_ENTRIES = 8
) (
    input  logic [NR_ENTRIES-1:0]                          match_i,
    input  logic [NR_ENTRIES-1:0][$clog2(NR_ENTRIES)-1:0]  age_i,
    output logic [NR_ENTRIES-1:0]                          sel_o
);

    localparam int AGE_W = $clog2(NR_ENTRIES);

    logic             found;
    logic [AGE_W-1:0] best_age;

    always_comb begin
        sel_o    = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (match_i[i] && (!found || age_i[i] > best_age)) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                best_age = age_i[i];
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_store_queue.sv
// In-order LSU store queue: insert, commit in order, drain committed stores to dcache; 1-cycle insert-to-visible.
// Drain holds payload while dc_wready_i is low; push stalls on registered full or flush.
// Store-to-load forwarding data path is built only with LSU_STORE_QUEUE_STLF_EN defined.
module lsu_store_queue
    import lsu_pkg::*;
#(
    parameter int NR_ENTRIES = 8,
    parameter int XLEN       = 64,
    parameter int ID_W       = 6
) (
    input  logic                          clk,
    input  logic                          rstn,

    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [ID_W-1:0]               push_id_i,
    input  logic [XLEN-1:0]               push_paddr_i,
    input  logic [1:0]                    push_size_i,
    input  logic [XLEN-1:0]               push_data_i,

    input  logic                          commit_i,
    input  logic                          flush_i,

    input  logic                          fwd_valid_i,
    input  logic [XLEN-1:0]               fwd_paddr_i,
    input  logic [1:0]                    fwd_size_i,
    output logic                          fwd_hit_o,
    output logic [XLEN-1:0]               fwd_data_o,
    output logic                          fwd_stall_o,

    output logic                          dc_wvalid_o,
    input  logic                          dc_wready_i,
    output logic [XLEN-1:0]               dc_waddr_o,
    output logic [XLEN-1:0]               dc_wdata_o,
    output logic [XLEN/8-1:0]             dc_wmask_o,

    output logic [$clog2(NR_ENTRIES):0]   count_o,
    output logic                          empty_o,
    output logic                          full_o
);

    localparam int IDX_W  = $clog2(NR_ENTRIES);
    localparam int PTR_W  = IDX_W + 1;
    localparam int MASK_W = XLEN / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q,  cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    sq_entry_t entries_q [NR_ENTRIES];
    sq_entry_t entries_d [NR_ENTRIES];
    sq_entry_t push_entry;
    sq_entry_t head_entry;

    logic [PTR_W-1:0] count;
    logic             full;
    logic             push_fire;
    logic             commit_fire;
    logic             drain_fire;
    logic [OFF_W-1:0] push_off;

    assign count        = tail_q - head_q;
    assign full         = (count == PTR_W'(NR_ENTRIES));
    assign push_ready_o = !full && !flush_i;
    assign push_fire    = push_valid_i && push_ready_o;
    // An empty-commit request is ignored so the pointer invariant survives a bad retire.
    assign commit_fire  = commit_i && (cmt_q != tail_q);
    assign dc_wvalid_o  = (head_q != cmt_q);
    assign drain_fire   = dc_wvalid_o && dc_wready_i;

    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = full;

    assign push_off = push_paddr_i[OFF_W-1:0];

    always_comb begin
        push_entry.id    = push_id_i;
        push_entry.addr  = {push_paddr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        push_entry.wdata = push_data_i << {push_off, 3'b000};
        push_entry.mask  = MASK_W'(size_to_mask(inst_size_t'(push_size_i))) << push_off;
    end

    always_comb begin
        head_d = head_q + PTR_W'(drain_fire);
        cmt_d  = cmt_q + PTR_W'(commit_fire);
        tail_d = tail_q + PTR_W'(push_fire);
        if (flush_i) begin
            tail_d = cmt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (push_fire) begin
            entries_d[tail_q[IDX_W-1:0]] = push_entry;
        end
    end

    // Payload storage carries no reset; validity comes solely from the pointers.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign head_entry = entries_q[head_q[IDX_W-1:0]];
    assign dc_waddr_o = head_entry.addr;
    assign dc_wdata_o = head_entry.wdata;
    assign dc_wmask_o = head_entry.mask;

    logic [MASK_W-1:0]                  ld_mask;
    logic [NR_ENTRIES-1:0][IDX_W-1:0]   ent_age;
    logic [NR_ENTRIES-1:0]              ent_match;
    logic                               any_match;

    assign ld_mask = MASK_W'(size_to_mask(inst_size_t'(fwd_size_i))) << fwd_paddr_i[OFF_W-1:0];

    always_comb begin
        ent_age   = '0;
        ent_match = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            ent_age[i]   = IDX_W'(i) - head_q[IDX_W-1:0];
            ent_match[i] = fwd_valid_i
                        && ({1'b0, ent_age[i]} < count)
                        && (entries_q[i].addr[XLEN-1:OFF_W] == fwd_paddr_i[XLEN-1:OFF_W])
                        && ((entries_q[i].mask & ld_mask) != '0);
        end
    end

    assign any_match = |ent_match;

`ifdef LSU_STORE_QUEUE_STLF_EN
    logic [NR_ENTRIES-1:0] fwd_sel;
    logic [MASK_W-1:0]     sel_mask;
    logic [XLEN-1:0]       sel_data;

    lsu_sq_fwd_match #(
        .NR_ENTRIES (NR_ENTRIES)
    ) u_fwd_match (
        .match_i (ent_match),
        .age_i   (ent_age),
        .sel_o   (fwd_sel)
    );

    always_comb begin
        sel_mask = '0;
        sel_data = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (fwd_sel[i]) begin
                sel_mask = sel_mask | entries_q[i].mask;
                sel_data = sel_data | entries_q[i].wdata;
            end
        end
    end

    assign fwd_hit_o   = any_match && ((sel_mask & ld_mask) == ld_mask);
    assign fwd_stall_o = any_match && !fwd_hit_o;
    assign fwd_data_o  = sel_data;
`else
    // Without a data path, any overlap with an older store must replay the load.
    assign fwd_hit_o   = 1'b0;
    assign fwd_stall_o = any_match;
    assign fwd_data_o  = '0;
`endif

    a_push_aligned: assert property (@(posedge clk) disable iff (!rstn)
        push_fire |-> size_aligned(inst_size_t'(push_size_i), push_paddr_i[2:0]));

    a_commit_nonempty: assert property (@(posedge clk) disable iff (!rstn)
        commit_i |-> (cmt_q != tail_q));

endmodule
